// File: rtl/lc3_scoreboard_pkg.sv
// Shared definitions for the LC-3 update scoreboard: FSM state encoding,
// error-code values and the fixed channel map of the tracked datapath writes.
package lc3_scoreboard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CHECK   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [1:0] ERR_PROTOCOL   = 2'd0;
  localparam logic [1:0] ERR_UNEXPECTED = 2'd1;
  localparam logic [1:0] ERR_MISMATCH   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT    = 2'd3;

  localparam int CH_MAR = 0;
  localparam int CH_MDR = 1;
  localparam int CH_PC  = 2;
  localparam int CH_IR  = 3;
  localparam int CH_MEM = 4;
  localparam int CH_R0  = 5;
  localparam int CH_R1  = 6;
  localparam int CH_R2  = 7;
  localparam int CH_R3  = 8;
  localparam int CH_R4  = 9;
  localparam int CH_R5  = 10;
  localparam int CH_R6  = 11;
  localparam int CH_R7  = 12;

endpackage

// File: rtl/lc3_scoreboard_slot.sv
// One scoreboard channel: holds the outstanding-expectation flag and the
// expected value, and compares it against the observed value on the bus.
module lc3_scoreboard_slot #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [DATA_W-1:0] set_value,
  input  logic              clr_en,
  input  logic [DATA_W-1:0] obs_value,
  output logic              pending,
  output logic              match
);

  logic [DATA_W-1:0] exp_q;

  // Pending flag: scheduling sets it, a resolved observation or flush clears it.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= 1'b0;
    end else if (set_en) begin
      pending <= 1'b1;
    end else if (clr_en) begin
      pending <= 1'b0;
    end
  end

  // Expected value: last scheduled value wins.
  // NOTE: the value register is deliberately not reset; it is only consulted while pending is set.
  always_ff @(posedge clk) begin
    if (set_en) begin
      exp_q <= set_value;
    end
  end

  assign match = (exp_q == obs_value);

endmodule

// File: rtl/lc3_update_scoreboard.sv
// LC-3 state-update scoreboard. Expectations are scheduled per channel, then
// observed write events are checked against them; errors, phase completion
// and saturating match/error counts are reported one cycle after sampling.
// Optional watchdog: define LC3_SCOREBOARD_TIMEOUT_EN to abort a stalled
// CHECK phase after TIMEOUT_CYC cycles with error code 3.
module lc3_update_scoreboard
  import lc3_scoreboard_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int NUM_CH      = 13,
  parameter int CH_W        = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exp_valid,
  input  logic [CH_W-1:0]   exp_ch,
  input  logic [DATA_W-1:0] exp_value,
  input  logic              arm,
  input  logic              obs_valid,
  input  logic [CH_W-1:0]   obs_ch,
  input  logic [DATA_W-1:0] obs_value,
  output logic [NUM_CH-1:0] pending,
  output logic              busy,
  output logic              phase_done,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [CH_W-1:0]   err_ch,
  output logic [CNT_W-1:0]  match_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  // Parameter sanity: the channel index must reach every channel.
  if ((1 << CH_W) < NUM_CH || TIMEOUT_CYC < 1) begin : g_param_check
    $error("lc3_update_scoreboard: CH_W too narrow for NUM_CH or TIMEOUT_CYC < 1");
  end

  state_t state_q, state_d;

  logic [NUM_CH-1:0] set_vec, clr_vec, match_vec, pend_after;
  logic              exp_ok, obs_ok;
  logic              exp_err, obs_err, match_inc;
  logic [1:0]        obs_code;
  logic [CH_W-1:0]   exp_err_ch;
  logic              err_d;
  logic [1:0]        code_d;
  logic [CH_W-1:0]   ch_d;

`ifdef LC3_SCOREBOARD_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic [CH_W-1:0] low_ch;
`endif

  assign exp_ok = ({1'b0, exp_ch} < NUM_CH_L);
  assign obs_ok = ({1'b0, obs_ch} < NUM_CH_L);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    lc3_scoreboard_slot #(.DATA_W(DATA_W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .set_en    (set_vec[i]),
      .set_value (exp_value),
      .clr_en    (clr_vec[i]),
      .obs_value (obs_value),
      .pending   (pending[i]),
      .match     (match_vec[i])
    );
  end

  // Decide slot updates, next state and the single error to report this cycle.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    set_vec    = '0;
    clr_vec    = '0;
    exp_err    = 1'b0;
    obs_err    = 1'b0;
    obs_code   = ERR_PROTOCOL;
    exp_err_ch = '0;
    match_inc  = 1'b0;
    err_d      = 1'b0;
    code_d     = ERR_PROTOCOL;
    ch_d       = '0;

    // Observation side: only CHECK with a pending channel accepts a write.
    if (obs_valid) begin
      if (!obs_ok) begin
        obs_err  = 1'b1;
        obs_code = ERR_PROTOCOL;
      end else if (state_q == ST_CHECK && pending[obs_ch]) begin
        clr_vec = NUM_CH'(1) << obs_ch;
        if (match_vec[obs_ch]) begin
          match_inc = 1'b1;
        end else begin
          obs_err  = 1'b1;
          obs_code = ERR_MISMATCH;
        end
      end else begin
        obs_err  = 1'b1;
        obs_code = ERR_UNEXPECTED;
      end
    end

    // Scheduling side: legal only in IDLE/COLLECT with an in-range channel.
    if (exp_valid) begin
      if (!exp_ok || state_q == ST_CHECK || state_q == ST_DONE) begin
        exp_err    = 1'b1;
        exp_err_ch = exp_ch;
      end else begin
        set_vec = NUM_CH'(1) << exp_ch;
      end
    end
    if (arm && state_q == ST_CHECK) begin
      exp_err = 1'b1;
    end

    pend_after = (pending | set_vec) & ~clr_vec;

    case (state_q)
      ST_IDLE: begin
        if (arm)            state_d = (|pend_after) ? ST_CHECK : ST_DONE;
        else if (|set_vec)  state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (arm)            state_d = (|pend_after) ? ST_CHECK : ST_DONE;
      end
      ST_CHECK: begin
        if (!(|pend_after)) state_d = ST_DONE;
      end
      default:              state_d = ST_IDLE;
    endcase

    // Observation errors win over scheduling errors; one report per cycle.
    if (obs_err) begin
      err_d  = 1'b1;
      code_d = obs_code;
      ch_d   = obs_ch;
    end else if (exp_err) begin
      err_d  = 1'b1;
      code_d = ERR_PROTOCOL;
      ch_d   = exp_err_ch;
    end

`ifdef LC3_SCOREBOARD_TIMEOUT_EN
    // Watchdog restarts on CHECK entry and on every accepted observation.
    low_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) low_ch = CH_W'(i);
    end
    wd_d = (state_q != ST_CHECK || (|clr_vec)) ? '0 : wd_q + WD_W'(1);
    if (state_q == ST_CHECK && !(|clr_vec) && wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
      clr_vec = '1;
      state_d = ST_DONE;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      ch_d    = low_ch;
    end
`else
    // No watchdog: CHECK waits for observations indefinitely.
`endif
  end

  // State, error pulse and saturating counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      err_valid   <= 1'b0;
      err_code    <= ERR_PROTOCOL;
      err_ch      <= '0;
      match_count <= '0;
      err_count   <= '0;
    end else begin
      state_q   <= state_d;
      err_valid <= err_d;
      err_code  <= code_d;
      err_ch    <= ch_d;
      if (match_inc && match_count != '1) match_count <= match_count + CNT_W'(1);
      if (err_d && err_count != '1)       err_count   <= err_count + CNT_W'(1);
    end
  end

`ifdef LC3_SCOREBOARD_TIMEOUT_EN
  // Watchdog cycle counter.
  always_ff @(posedge clk) begin
    if (!rst) wd_q <= '0;
    else      wd_q <= wd_d;
  end
`endif

  assign busy       = (state_q == ST_COLLECT) || (state_q == ST_CHECK);
  assign phase_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_lc3_update_scoreboard.sv
// Directed bench for lc3_update_scoreboard: a cycle-by-cycle vector table
// followed by hand-written reset and watchdog sequences.
module tb_lc3_update_scoreboard;

  localparam int DATA_W = 16;
  localparam int NUM_CH = 13;
  localparam int CH_W   = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              exp_valid = 1'b0;
  logic [CH_W-1:0]   exp_ch = '0;
  logic [DATA_W-1:0] exp_value = '0;
  logic              arm = 1'b0;
  logic              obs_valid = 1'b0;
  logic [CH_W-1:0]   obs_ch = '0;
  logic [DATA_W-1:0] obs_value = '0;
  logic [NUM_CH-1:0] pending;
  logic              busy, phase_done, err_valid;
  logic [1:0]        err_code;
  logic [CH_W-1:0]   err_ch;
  logic [CNT_W-1:0]  match_count, err_count;

  always #5 clk = ~clk;

  lc3_update_scoreboard #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst(rst),
    .exp_valid(exp_valid), .exp_ch(exp_ch), .exp_value(exp_value), .arm(arm),
    .obs_valid(obs_valid), .obs_ch(obs_ch), .obs_value(obs_value),
    .pending(pending), .busy(busy), .phase_done(phase_done),
    .err_valid(err_valid), .err_code(err_code), .err_ch(err_ch),
    .match_count(match_count), .err_count(err_count)
  );

  typedef struct {
    string       name;
    logic        r;
    logic        ev;  logic [3:0] ech; logic [15:0] evl;
    logic        arm;
    logic        ov;  logic [3:0] och; logic [15:0] ovl;
    logic [12:0] pend;
    logic        busy, done, errv;
    logic [1:0]  code;
    logic [3:0]  ech_o;
    logic [15:0] mc, ec;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [63:0] pack(input logic [12:0] p, input logic b, input logic d,
                                       input logic e, input logic [1:0] c, input logic [3:0] ch,
                                       input logic [15:0] mc, input logic [15:0] ec);
    return {10'b0, p, b, d, e, c, ch, mc, ec};
  endfunction

  function automatic logic [63:0] observed();
    return pack(pending, busy, phase_done, err_valid, err_code, err_ch, match_count, err_count);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // One clock cycle of stimulus; outputs are settled 1 time unit after the edge.
  task automatic drive(input logic ev, input logic [3:0] ech, input logic [15:0] evl,
                       input logic a, input logic ov, input logic [3:0] och,
                       input logic [15:0] ovl);
    @(negedge clk);
    exp_valid = ev;  exp_ch = ech;  exp_value = evl;
    arm       = a;
    obs_valid = ov;  obs_ch = och;  obs_value = ovl;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input logic r,
                     input logic ev, input logic [3:0] ech, input logic [15:0] evl, input logic a,
                     input logic ov, input logic [3:0] och, input logic [15:0] ovl,
                     input logic [12:0] p, input logic b, input logic d, input logic e,
                     input logic [1:0] c, input logic [3:0] ch, input logic [15:0] mc,
                     input logic [15:0] ec);
    vec_t v;
    v.name = n; v.r = r; v.ev = ev; v.ech = ech; v.evl = evl; v.arm = a;
    v.ov = ov; v.och = och; v.ovl = ovl; v.pend = p; v.busy = b; v.done = d;
    v.errv = e; v.code = c; v.ech_o = ch; v.mc = mc; v.ec = ec;
    vecs.push_back(v);
  endtask

  initial begin
    logic [63:0] snap;
    logic        seen;
    int          waited;

    //   name          r  ev ech  evl      arm ov och  ovl      pend      b  d  e  code ch    mc  ec
    add("reset",       0, 0, 4'h0, 16'h0000, 0, 0, 4'h0, 16'h0000, 13'h0000, 0, 0, 0, 2'd0, 4'h0, 0, 0);
    add("t1_sched",    1, 1, 4'h5, 16'h1234, 0, 0, 4'h0, 16'h0000, 13'h0020, 1, 0, 0, 2'd0, 4'h0, 0, 0);
    add("t1_arm",      1, 0, 4'h0, 16'h0000, 1, 0, 4'h0, 16'h0000, 13'h0020, 1, 0, 0, 2'd0, 4'h0, 0, 0);
    add("t1_match",    1, 0, 4'h0, 16'h0000, 0, 1, 4'h5, 16'h1234, 13'h0000, 0, 1, 0, 2'd0, 4'h0, 1, 0);
    add("t1_idle",     1, 0, 4'h0, 16'h0000, 0, 0, 4'h0, 16'h0000, 13'h0000, 0, 0, 0, 2'd0, 4'h0, 1, 0);
    add("t2_sch_arm",  1, 1, 4'h2, 16'h3001, 1, 0, 4'h0, 16'h0000, 13'h0004, 1, 0, 0, 2'd0, 4'h0, 1, 0);
    add("t2_mismatch", 1, 0, 4'h0, 16'h0000, 0, 1, 4'h2, 16'h3000, 13'h0000, 0, 1, 1, 2'd2, 4'h2, 1, 1);
    add("t2_idle",     1, 0, 4'h0, 16'h0000, 0, 0, 4'h0, 16'h0000, 13'h0000, 0, 0, 0, 2'd0, 4'h0, 1, 1);
    add("t3_sched",    1, 1, 4'h0, 16'hABCD, 0, 0, 4'h0, 16'h0000, 13'h0001, 1, 0, 0, 2'd0, 4'h0, 1, 1);
    add("t3_resched",  1, 1, 4'h0, 16'h5555, 0, 0, 4'h0, 16'h0000, 13'h0001, 1, 0, 0, 2'd0, 4'h0, 1, 1);
    add("t3_arm",      1, 0, 4'h0, 16'h0000, 1, 0, 4'h0, 16'h0000, 13'h0001, 1, 0, 0, 2'd0, 4'h0, 1, 1);
    add("t3_unexp",    1, 0, 4'h0, 16'h0000, 0, 1, 4'h7, 16'h0000, 13'h0001, 1, 0, 1, 2'd1, 4'h7, 1, 2);
    add("t3_match",    1, 0, 4'h0, 16'h0000, 0, 1, 4'h0, 16'h5555, 13'h0000, 0, 1, 0, 2'd0, 4'h0, 2, 2);
    add("t3_idle",     1, 0, 4'h0, 16'h0000, 0, 0, 4'h0, 16'h0000, 13'h0000, 0, 0, 0, 2'd0, 4'h0, 2, 2);
    add("t4_empty",    1, 0, 4'h0, 16'h0000, 1, 0, 4'h0, 16'h0000, 13'h0000, 0, 1, 0, 2'd0, 4'h0, 2, 2);
    add("t4_idle",     1, 0, 4'h0, 16'h0000, 0, 0, 4'h0, 16'h0000, 13'h0000, 0, 0, 0, 2'd0, 4'h0, 2, 2);
    add("t4_sched",    1, 1, 4'h1, 16'h1111, 0, 0, 4'h0, 16'h0000, 13'h0002, 1, 0, 0, 2'd0, 4'h0, 2, 2);
    add("t4_arm",      1, 0, 4'h0, 16'h0000, 1, 0, 4'h0, 16'h0000, 13'h0002, 1, 0, 0, 2'd0, 4'h0, 2, 2);
    add("t4_exp_chk",  1, 1, 4'h4, 16'h2222, 0, 0, 4'h0, 16'h0000, 13'h0002, 1, 0, 1, 2'd0, 4'h4, 2, 3);
    add("t4_arm_chk",  1, 0, 4'h0, 16'h0000, 1, 0, 4'h0, 16'h0000, 13'h0002, 1, 0, 1, 2'd0, 4'h0, 2, 4);
    add("t4_bad_exp",  1, 1, 4'hD, 16'h0000, 0, 1, 4'h1, 16'h1111, 13'h0000, 0, 1, 1, 2'd0, 4'hD, 3, 5);
    add("t4_idle",     1, 0, 4'h0, 16'h0000, 0, 0, 4'h0, 16'h0000, 13'h0000, 0, 0, 0, 2'd0, 4'h0, 3, 5);
    add("pr_sched",    1, 1, 4'h3, 16'h0007, 0, 0, 4'h0, 16'h0000, 13'h0008, 1, 0, 0, 2'd0, 4'h0, 3, 5);
    add("pr_arm",      1, 0, 4'h0, 16'h0000, 1, 0, 4'h0, 16'h0000, 13'h0008, 1, 0, 0, 2'd0, 4'h0, 3, 5);
    add("pr_both",     1, 1, 4'h2, 16'h0009, 0, 1, 4'h6, 16'h0000, 13'h0008, 1, 0, 1, 2'd1, 4'h6, 3, 6);
    add("pr_bad_obs",  1, 0, 4'h0, 16'h0000, 0, 1, 4'hF, 16'h0000, 13'h0008, 1, 0, 1, 2'd0, 4'hF, 3, 7);
    add("pr_match",    1, 0, 4'h0, 16'h0000, 0, 1, 4'h3, 16'h0007, 13'h0000, 0, 1, 0, 2'd0, 4'h0, 4, 7);
    add("obs_in_done", 1, 0, 4'h0, 16'h0000, 0, 1, 4'h3, 16'h0007, 13'h0000, 0, 0, 1, 2'd1, 4'h3, 4, 8);
    add("obs_in_idle", 1, 0, 4'h0, 16'h0000, 0, 1, 4'h3, 16'h0007, 13'h0000, 0, 0, 1, 2'd1, 4'h3, 4, 9);
    add("obs_in_coll", 1, 1, 4'h8, 16'h0042, 0, 1, 4'h8, 16'h0042, 13'h0100, 1, 0, 1, 2'd1, 4'h8, 4, 10);
    add("m_arm_sched", 1, 1, 4'h9, 16'h0043, 1, 0, 4'h0, 16'h0000, 13'h0300, 1, 0, 0, 2'd0, 4'h0, 4, 10);
    add("m_match9",    1, 0, 4'h0, 16'h0000, 0, 1, 4'h9, 16'h0043, 13'h0100, 1, 0, 0, 2'd0, 4'h0, 5, 10);
    add("m_mism8",     1, 0, 4'h0, 16'h0000, 0, 1, 4'h8, 16'h0041, 13'h0000, 0, 1, 1, 2'd2, 4'h8, 5, 11);
    add("m_idle",      1, 0, 4'h0, 16'h0000, 0, 0, 4'h0, 16'h0000, 13'h0000, 0, 0, 0, 2'd0, 4'h0, 5, 11);
    add("bad_exp_idl", 1, 1, 4'hE, 16'h0000, 0, 0, 4'h0, 16'h0000, 13'h0000, 0, 0, 1, 2'd0, 4'hE, 5, 12);
    add("end_idle",    1, 0, 4'h0, 16'h0000, 0, 0, 4'h0, 16'h0000, 13'h0000, 0, 0, 0, 2'd0, 4'h0, 5, 12);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].r;
      drive(vecs[i].ev, vecs[i].ech, vecs[i].evl, vecs[i].arm, vecs[i].ov, vecs[i].och, vecs[i].ovl);
      check(vecs[i].name, observed(),
            pack(vecs[i].pend, vecs[i].busy, vecs[i].done, vecs[i].errv, vecs[i].code,
                 vecs[i].ech_o, vecs[i].mc, vecs[i].ec));
    end

    // Reset in the middle of CHECK with three channels outstanding.
    rst = 1'b1;
    drive(1, 4'hA, 16'h0A0A, 0, 0, 4'h0, 16'h0000);
    drive(1, 4'hB, 16'h0B0B, 0, 0, 4'h0, 16'h0000);
    drive(1, 4'hC, 16'h0C0C, 1, 0, 4'h0, 16'h0000);
    check("rst_pre_pend", 64'(pending), 64'h1C00);
    rst = 1'b0;
    drive(1, 4'h3, 16'h0003, 0, 1, 4'hA, 16'h0A0A);
    check("rst_mid_check", observed(), pack(13'h0000, 0, 0, 0, 2'd0, 4'h0, 0, 0));
    rst = 1'b1;
    drive(1, 4'hC, 16'hBEEF, 1, 0, 4'h0, 16'h0000);
    check("rst_fresh_arm", observed(), pack(13'h1000, 1, 0, 0, 2'd0, 4'h0, 0, 0));
    drive(0, 4'h0, 16'h0000, 0, 1, 4'hC, 16'hBEEF);
    check("rst_fresh_done", observed(), pack(13'h0000, 0, 1, 0, 2'd0, 4'h0, 1, 0));
    drive(0, 4'h0, 16'h0000, 0, 0, 4'h0, 16'h0000);

    // Stalled CHECK phase with channels 3 and 9 outstanding.
    drive(1, 4'h3, 16'h0003, 0, 0, 4'h0, 16'h0000);
    drive(1, 4'h9, 16'h0009, 1, 0, 4'h0, 16'h0000);
    check("stall_arm", observed(), pack(13'h0208, 1, 0, 0, 2'd0, 4'h0, 1, 0));
`ifdef LC3_SCOREBOARD_TIMEOUT_EN
    seen   = 1'b0;
    waited = 0;
    snap   = '0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      drive(0, 4'h0, 16'h0000, 0, 0, 4'h0, 16'h0000);
      if (err_valid) begin
        seen   = 1'b1;
        waited = k;
        snap   = observed();
      end
    end
    check("timeout_seen", 64'(seen), 64'd1);
    check("timeout_cycles", 64'(waited), 64'd8);
    check("timeout_report", snap, pack(13'h0000, 0, 1, 1, 2'd3, 4'h3, 1, 1));
`else
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive(0, 4'h0, 16'h0000, 0, 0, 4'h0, 16'h0000);
      if (err_valid) seen = 1'b1;
    end
    check("no_watchdog_err", 64'(seen), 64'd0);
    check("no_watchdog_wait", observed(), pack(13'h0208, 1, 0, 0, 2'd0, 4'h0, 1, 0));
    drive(0, 4'h0, 16'h0000, 0, 1, 4'h3, 16'h0003);
    drive(0, 4'h0, 16'h0000, 0, 1, 4'h9, 16'h0009);
    check("no_watchdog_done", observed(), pack(13'h0000, 0, 1, 0, 2'd0, 4'h0, 3, 0));
`endif
    drive(0, 4'h0, 16'h0000, 0, 0, 4'h0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_update_scoreboard.md
Name: lc3_update_scoreboard

Overview:
Synthesizable, parametrised scoreboard that checks LC-3 state updates per instruction phase (fetch or execute).
- A stimulus source schedules expected updates per channel (MAR, MDR, PC, MEMORY, R0..R7, NZP, ...) with expected values.
- The block then compares observed datapath write events against those expectations.
- It reports mismatches, unexpected writes and phase completion, and keeps match/error counts.
- It sits beside the lc3 core in the bench/FPGA test harness, fed by a random instruction generator and by write-strobe taps.

Parameters:
DATA_W, 16, width of expected/observed values
NUM_CH, 13, number of tracked update channels (index 0..NUM_CH-1)
CH_W, 4, width of channel index; must satisfy 2**CH_W >= NUM_CH
CNT_W, 16, width of match/error counters
TIMEOUT_CYC, 64, watchdog limit in CHECK state (used only with optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
exp_valid  in  1  schedule an expected update this cycle
exp_ch  in  CH_W  channel to schedule
exp_value  in  DATA_W  expected value
arm  in  1  end of scheduling; begin checking
obs_valid  in  1  observed write event this cycle
obs_ch  in  CH_W  channel written
obs_value  in  DATA_W  value written
pending  out  NUM_CH  per-channel outstanding-expectation flags
busy  out  1  high in COLLECT or CHECK
phase_done  out  1  one-cycle pulse: all expectations resolved
err_valid  out  1  one-cycle error pulse
err_code  out  2  0=protocol, 1=unexpected, 2=mismatch, 3=timeout
err_ch  out  CH_W  channel of reported error
match_count  out  CNT_W  saturating count of correct updates
err_count  out  CNT_W  saturating count of error pulses

Behaviour:
- Reset (rst=0 at a clock edge):
  - state IDLE; pending=0, busy=0, phase_done=0, err_valid=0, err_code=0, err_ch=0, match_count=0, err_count=0.
  - Reset mid-phase discards all expectations.
- States:
  - IDLE: any exp_valid moves to COLLECT and captures that expectation.
  - COLLECT: exp_valid sets pending[exp_ch] and stores exp_value. Re-scheduling an already-pending channel overwrites the value (last wins).
  - arm in COLLECT: arm together with exp_valid captures the expectation first, then evaluates. If pending (after capture) is nonzero, go to CHECK; if zero, go to DONE.
  - arm in IDLE with no exp_valid: go straight to DONE (empty phase).
  - CHECK, obs_valid with pending[obs_ch]=1:
    - clear pending[obs_ch].
    - value equal: match_count+1.
    - value unequal: err_valid, code 2, err_ch=obs_ch.
  - CHECK, obs_valid with pending[obs_ch]=0: err_valid, code 1. Nothing else changes.
  - CHECK exit: when the last pending bit clears, go to DONE on the next edge.
  - DONE: phase_done=1 for exactly one cycle, then IDLE. busy=0 in DONE and IDLE.
- Latency: a decision on an input sampled at edge t appears at outputs after edge t (registered, 1 cycle). phase_done is asserted the cycle after the last pending bit clears.
- Protocol errors (err code 0; input otherwise ignored):
  - exp_valid in CHECK or DONE
  - any exp_ch/obs_ch >= NUM_CH
  - arm while in CHECK
- obs_valid in IDLE/COLLECT/DONE: err code 1 (unexpected).
- Simultaneous errors in one cycle: report one only; the obs-side error has priority over the exp-side error. err_count increments by 1.
- Counters saturate at all-ones; they never wrap.

Optional Feature:
Macro LC3_SCOREBOARD_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in CHECK since entry or since the last accepted obs.
  - On reaching TIMEOUT_CYC: err_valid, code 3, err_ch = lowest pending index, all pending cleared, go to DONE.
- Undefined: no watchdog logic; code 3 is never produced; CHECK may wait indefinitely.

Decomposition:
- Package lc3_scoreboard_pkg holds:
  - state encoding (IDLE, COLLECT, CHECK, DONE)
  - err_code constants
  - channel index constants: CH_MAR=0, CH_MDR=1, CH_PC=2, CH_IR=3, CH_MEM=4, CH_R0..CH_R7=5..12
- One sub-module, lc3_scoreboard_slot: per-channel pending flag, expected-value register and compare. Instantiated NUM_CH times via generate.

Test Plan:
1. Schedule ch5 (R0)=0x1234, arm, obs ch5 0x1234 -> match_count=1, err_count=0, phase_done pulses 1 cycle after the obs cycle.
2. Schedule ch2=0x3001, arm, obs ch2 0x3000 -> err_valid, code 2, err_ch=2, err_count=1, phase_done follows.
3. Schedule ch0, arm, obs ch7 first -> err code 1 err_ch=7; then obs ch0 matching -> done. Totals: match 1, err 1.
4. arm with nothing scheduled -> phase_done next cycle, no error; exp_valid during CHECK -> code 0.
5. With LC3_SCOREBOARD_TIMEOUT_EN, TIMEOUT_CYC=8: schedule ch3 and ch9, arm, no obs -> code 3 err_ch=3 after 8 CHECK cycles, pending=0, phase_done.
6. rst=0 while in CHECK with 3 pending -> next cycle pending=0, counters 0, busy=0, IDLE; a fresh phase then completes normally.
